// File: rtl/acc_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_multi_if
// Purpose  : Bundles the sample, dump-control and result-stream signals of acc_multi.
// Revision : 1.0
// ============================================================================
interface acc_multi_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int CH_W       = 2
);
  localparam int NUM_CH = 2**CH_W;

  logic                  in_valid;
  logic [CH_W-1:0]       in_ch;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  clear;
  logic                  dump_req;
  logic                  dump_busy;
  logic                  out_valid;
  logic [CH_W-1:0]       out_ch;
  logic [ACC_WIDTH-1:0]  data_out;
  logic                  out_ovf;
  logic [NUM_CH-1:0]     ovf;

  modport master (
    output in_valid, in_ch, data_in, clear, dump_req,
    input  dump_busy, out_valid, out_ch, data_out, out_ovf, ovf
  );

  modport slave (
    input  in_valid, in_ch, data_in, clear, dump_req,
    output dump_busy, out_valid, out_ch, data_out, out_ovf, ovf
  );
endinterface
`default_nettype wire

// File: rtl/acc_multi.sv
`default_nettype none
// ============================================================================
// Module   : acc_multi
// Purpose  : NUM_CH unsigned accumulators with sticky overflow flags and a
//            read-and-clear dump sequencer. Define ACC_SAT_EN to saturate
//            instead of wrap on overflow.
// Revision : 1.0
// ============================================================================
module acc_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int CH_W       = 2
) (
  input  logic       clk,
  input  logic       reset,
  acc_multi_if.slave bus
);
  localparam int NUM_CH = 2**CH_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DUMP = 1'b1;

  logic [0:0]                         state_q, state_d;
  logic [CH_W-1:0]                    k_q, k_d;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [NUM_CH-1:0]                  ovf_q, ovf_d;
  logic                               out_valid_q, out_valid_d;
  logic [CH_W-1:0]                    out_ch_q, out_ch_d;
  logic [ACC_WIDTH-1:0]               data_out_q, data_out_d;
  logic                               out_ovf_q, out_ovf_d;

  logic [ACC_WIDTH-1:0]               sample_ext;
  logic [ACC_WIDTH:0]                 sum;
  logic [ACC_WIDTH-1:0]               acc_next;

  assign sample_ext = ACC_WIDTH'(bus.data_in);
  assign sum        = {1'b0, acc_q[bus.in_ch]} + {1'b0, sample_ext};

`ifdef ACC_SAT_EN
  assign acc_next = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign acc_next = sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    data_out_d  = data_out_q;
    out_ovf_d   = out_ovf_q;

    if (bus.clear) begin
      acc_d   = '0;
      ovf_d   = '0;
      state_d = IDLE;
      k_d     = '0;
    end else begin
      if (bus.in_valid) begin
        acc_d[bus.in_ch] = acc_next;
        if (sum[ACC_WIDTH]) begin
          ovf_d[bus.in_ch] = 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.dump_req) begin
            state_d = DUMP;
            k_d     = '0;
          end
        end
        DUMP: begin
          out_valid_d = 1'b1;
          out_ch_d    = k_q;
          data_out_d  = acc_q[k_q];
          out_ovf_d   = ovf_q[k_q];
          // A sample hitting the channel being read starts its fresh sum.
          acc_d[k_q]  = (bus.in_valid && (bus.in_ch == k_q)) ? sample_ext : '0;
          ovf_d[k_q]  = 1'b0;
          k_d         = k_q + CH_W'(1);
          if (k_q == CH_W'(NUM_CH - 1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      data_out_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      data_out_q  <= data_out_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.dump_busy = (state_q == DUMP);
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.data_out  = data_out_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_acc_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_multi
// Purpose  : Directed and random stimulus for acc_multi against a reference model.
// Revision : 1.0
// ============================================================================
module tb_acc_multi;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int CW  = 2;
  localparam int NCH = 4;
  localparam int unsigned MAXV = 65535;
`ifdef ACC_SAT_EN
  localparam int unsigned OVF_EXP = 65535;
`else
  localparam int unsigned OVF_EXP = 10964;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  acc_multi_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CH_W(CW)) bus ();
  acc_multi #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CH_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int unsigned m_acc [NCH];
  bit          m_ovf [NCH];
  bit          m_busy;
  int          m_idx;
  bit          e_valid;
  int          e_ch;
  int unsigned e_data;
  bit          e_ovf;

  typedef struct {
    int          ch;
    int unsigned data;
    bit          ovf;
    int          cyc;
  } rec_t;
  rec_t cap[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input int ch, input int d, input bit clr, input bit dr);
    bus.in_valid = v;
    bus.in_ch    = CW'(ch);
    bus.data_in  = DW'(d);
    bus.clear    = clr;
    bus.dump_req = dr;
  endtask

  task automatic model_add(input int ch, input int unsigned d);
    int unsigned s;
    s = m_acc[ch] + d;
    if (s > MAXV) begin
      m_ovf[ch] = 1'b1;
`ifdef ACC_SAT_EN
      s = MAXV;
`else
      s = s - (MAXV + 1);
`endif
    end
    m_acc[ch] = s;
  endtask

  // One clock: advance the model from the sampled inputs, then compare.
  task automatic tick();
    int d;
    logic [NCH-1:0] ovf_vec;
    @(posedge clk);
    cyc++;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
      m_busy = 0; m_idx = 0; e_valid = 0; e_ch = 0; e_data = 0; e_ovf = 0;
    end else if (bus.clear) begin
      for (int i = 0; i < NCH; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
      m_busy = 0; m_idx = 0; e_valid = 0;
    end else begin
      d = m_idx;
      e_valid = m_busy;
      if (m_busy) begin
        e_ch = d; e_data = m_acc[d]; e_ovf = m_ovf[d];
      end
      if (bus.in_valid) model_add(int'(bus.in_ch), int'(bus.data_in));
      if (m_busy) begin
        m_acc[d] = (bus.in_valid && int'(bus.in_ch) == d) ? int'(bus.data_in) : 0;
        m_ovf[d] = 0;
        m_idx++;
        if (m_idx == NCH) m_busy = 0;
      end else if (bus.dump_req) begin
        m_busy = 1; m_idx = 0;
      end
    end
    #1;
    for (int i = 0; i < NCH; i++) ovf_vec[i] = m_ovf[i];
    chk("out_valid", 64'(bus.out_valid), 64'(e_valid));
    chk("dump_busy", 64'(bus.dump_busy), 64'(m_busy));
    chk("ovf_vec",   64'(bus.ovf),       64'(ovf_vec));
    if (e_valid) begin
      chk("out_ch",   64'(bus.out_ch),   64'(e_ch));
      chk("data_out", 64'(bus.data_out), 64'(e_data));
      chk("out_ovf",  64'(bus.out_ovf),  64'(e_ovf));
    end
    if (bus.out_valid === 1'b1) begin
      cap.push_back('{ch: int'(bus.out_ch), data: int'(bus.data_out), ovf: bus.out_ovf, cyc: cyc});
    end
  endtask

  task automatic dump_run();
    cap.delete();
    set_in(0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    repeat (NCH + 1) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_n"}, 64'(cap.size()), 64'(NCH));
    for (int i = 0; i < cap.size() && i < NCH; i++) begin
      chk({tag, "_ch"},  64'(cap[i].ch),   64'(i));
      chk({tag, "_val"}, 64'(cap[i].data), 64'(0));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_busy"},  64'(bus.dump_busy), 64'(0));
    chk({tag, "_ch"},    64'(bus.out_ch),    64'(0));
    chk({tag, "_data"},  64'(bus.data_out),  64'(0));
    chk({tag, "_oovf"},  64'(bus.out_ovf),   64'(0));
    chk({tag, "_ovf"},   64'(bus.ovf),       64'(0));
  endtask

  initial begin : stim
    int unsigned exp1 [NCH];
    exp1[0] = 12; exp1[1] = 0; exp1[2] = 0; exp1[3] = 200;

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk_reset_outputs("reset");

    // Basic accumulate and dump
    set_in(1, 0, 5, 0, 0);   tick();
    set_in(1, 0, 7, 0, 0);   tick();
    set_in(1, 3, 200, 0, 0); tick();
    set_in(0, 0, 0, 0, 0);
    dump_run();
    chk("basic_n", 64'(cap.size()), 64'(NCH));
    for (int i = 0; i < cap.size() && i < NCH; i++) begin
      chk("basic_ch",  64'(cap[i].ch),   64'(i));
      chk("basic_val", 64'(cap[i].data), 64'(exp1[i]));
      chk("basic_ovf", 64'(cap[i].ovf),  64'(0));
    end
    chk("basic_consec", 64'(cap.size() == NCH ? cap[NCH-1].cyc - cap[0].cyc : 0), 64'(NCH - 1));
    dump_run();
    chk_all_zero("after_basic");

    // Overflow on ch1: 300 x 255
    repeat (300) begin
      set_in(1, 1, 255, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("ovf1_live", 64'(bus.ovf[1]), 64'(1));
    dump_run();
    chk("ovf_n", 64'(cap.size()), 64'(NCH));
    if (cap.size() > 1) begin
      chk("ovf_val",  64'(cap[1].data), 64'(OVF_EXP));
      chk("ovf_flag", 64'(cap[1].ovf),  64'(1));
    end
    chk("ovf_cleared", 64'(bus.ovf), 64'(0));

    // Collision: sample into ch2 in the cycle ch2 is dumped
    set_in(1, 2, 50, 0, 0); tick();
    cap.delete();
    set_in(0, 0, 0, 0, 1);  tick();
    set_in(0, 0, 0, 0, 0);  tick(); tick();
    set_in(1, 2, 9, 0, 0);  tick();
    set_in(0, 0, 0, 0, 0);  tick(); tick();
    chk("coll_n", 64'(cap.size()), 64'(NCH));
    if (cap.size() > 2) chk("coll_old", 64'(cap[2].data), 64'(50));
    dump_run();
    if (cap.size() > 2) chk("coll_new", 64'(cap[2].data), 64'(9));

    // Clear mid-dump while ch1 is on the outputs
    for (int i = 0; i < NCH; i++) begin
      set_in(1, i, i + 1, 0, 0);
      tick();
    end
    cap.delete();
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0); tick(); tick();
    set_in(0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0);
    chk("clr_valid", 64'(bus.out_valid), 64'(0));
    chk("clr_busy",  64'(bus.dump_busy), 64'(0));
    tick(); tick();
    chk("clr_n", 64'(cap.size()), 64'(2));
    if (cap.size() > 1) begin
      chk("clr_v0", 64'(cap[0].data), 64'(1));
      chk("clr_v1", 64'(cap[1].data), 64'(2));
    end
    dump_run();
    chk_all_zero("after_clr");

    // dump_req held across a whole dump
    set_in(1, 3, 17, 0, 0); tick();
    cap.delete();
    set_in(0, 0, 0, 0, 1);
    repeat (10) tick();
    set_in(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("held_n", 64'(cap.size()), 64'(2 * NCH));
    if (cap.size() == 2 * NCH) begin
      chk("held_gap", 64'(cap[NCH].cyc - cap[NCH-1].cyc), 64'(2));
      chk("held_v3",  64'(cap[3].data), 64'(17));
      for (int i = 0; i < 2 * NCH; i++) chk("held_ch", 64'(cap[i].ch), 64'(i % NCH));
    end

    // Random traffic
    repeat (400) begin
      set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)),
             int'($urandom_range(0, 255)), $urandom_range(0, 63) == 0,
             $urandom_range(0, 7) == 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    repeat (NCH + 1) tick();

    // Reset mid-dump
    set_in(1, 1, 33, 0, 0); tick();
    set_in(0, 0, 0, 0, 1);  tick();
    set_in(0, 0, 0, 0, 0);  tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outputs("rst_mid");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
